// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA burst read path.
package dma_pkg;

   localparam int DMA_DATA_W = 32;
   localparam int DMA_CNT_W  = 28;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } dma_state_e;

   // Length of a partial burst: whatever is queued, capped at a full burst,
   // and never 0 (a non-empty FIFO can briefly report a zero count).
   function automatic logic [15:0] clamp_len(input logic [DMA_CNT_W-1:0] cnt,
                                             input logic [15:0]          max_len);
      if (cnt == '0)
         return 16'd1;
      else if (cnt >= {{(DMA_CNT_W-16){1'b0}}, max_len})
         return max_len;
      else
         return cnt[15:0];
   endfunction

endpackage

// File: rtl/dma_skid_fifo.sv
// Small first-word-fall-through FIFO that absorbs the merge FIFO read latency.
module dma_skid_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     push_i,
   input  logic [DATA_W-1:0]        push_dat_i,
   input  logic                     pop_i,
   output logic [DATA_W-1:0]        head_dat_o,
   output logic [$clog2(DEPTH):0]   occ_o,
   output logic                     empty_o,
   output logic                     full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       occ;
   logic              do_push;
   logic              do_pop;

   assign empty_o    = (occ == '0);
   assign full_o     = (occ == DEPTH_C);
   assign do_push    = push_i && !full_o;
   assign do_pop     = pop_i && !empty_o;
   assign occ_o      = occ;
   // Head is forced to 0 when empty so the stream data is clean out of reset.
   assign head_dat_o = empty_o ? '0 : mem[rd_ptr];

   // Pointer and occupancy tracking.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Storage array, no reset needed since the head is masked while empty.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= push_dat_i;
   end

endmodule

// File: rtl/dma_burst_reader.sv
// Drains the merge FIFO in bursts and presents them as a valid/ready stream.
//
//  state | meaning
//  IDLE  | waiting for a full burst, a timeout or a flush to arm
//  READ  | issuing merge FIFO reads until the burst length is requested
//  DRAIN | all reads issued, streaming out the remaining words
module dma_burst_reader
   import dma_pkg::*;
#(
   parameter int DATA_W     = DMA_DATA_W,
   parameter int BURST_LEN  = 64,
   parameter int TIMEOUT    = 1024,
   parameter int SKID_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  enable_i,
   input  logic                  flush_i,
   output logic                  fifo_rd_o,
   input  logic [DATA_W-1:0]     fifo_rd_dat_i,
   input  logic                  fifo_rd_dat_valid_i,
   input  logic                  fifo_empty_i,
   input  logic [DMA_CNT_W-1:0]  fifo_rd_data_count_i,
   output logic [DATA_W-1:0]     dma_dat_o,
   output logic                  dma_valid_o,
   input  logic                  dma_ready_i,
   output logic                  dma_last_o,
   output logic                  dma_burst_start_o,
   output logic [15:0]           dma_burst_len_o,
   output logic                  busy_o,
   output logic [31:0]           burst_count_o,
   output logic                  error_o
);

   localparam int OW = $clog2(SKID_DEPTH) + 1;
   localparam logic [15:0]          BURST_LEN_C = BURST_LEN[15:0];
   localparam logic [DMA_CNT_W-1:0] BURST_LEN_W = BURST_LEN[DMA_CNT_W-1:0];
   localparam logic [15:0]          TIMEOUT_C   = TIMEOUT[15:0];
   localparam logic [OW:0]          SKID_LIM    = SKID_DEPTH[OW:0];

   dma_state_e        state;
   logic [15:0]       len_q;
   logic [15:0]       rd_left;
   logic [15:0]       out_idx;
   logic [15:0]       timer;
   logic              inflight;
   logic              start_q;
   logic              error_q;
   logic [31:0]       burst_cnt;

   logic              skid_push;
   logic              skid_empty;
   logic              skid_full;
   logic [OW-1:0]     skid_occ;
   logic [DATA_W-1:0] skid_head;
   logic [OW:0]       pending;
   logic              xfer;
   logic              last_word;
   logic              arm_full;
   logic              arm_part;
   logic              arm;
   logic [15:0]       arm_len;

   // Words already in the skid plus the one still coming back from the FIFO.
   assign pending   = {1'b0, skid_occ} + {{OW{1'b0}}, inflight};
   assign fifo_rd_o = (state == READ) && (rd_left != 16'd0) && !fifo_empty_i
                      && (pending < SKID_LIM);

   // Only data we actually asked for enters the stream; stray valids just flag an error.
   assign skid_push = fifo_rd_dat_valid_i && inflight;

   assign dma_valid_o = !skid_empty;
   assign dma_dat_o   = skid_head;
   assign xfer        = dma_valid_o && dma_ready_i;
   assign last_word   = (out_idx == len_q - 16'd1);
   assign dma_last_o  = dma_valid_o && last_word;

   assign arm_full = enable_i && (fifo_rd_data_count_i >= BURST_LEN_W);
   assign arm_part = enable_i && !fifo_empty_i && ((timer == 16'd0) || flush_i);
   assign arm      = (state == IDLE) && (arm_full || arm_part);
   assign arm_len  = arm_full ? BURST_LEN_C : clamp_len(fifo_rd_data_count_i, BURST_LEN_C);

   assign busy_o            = (state != IDLE);
   assign dma_burst_start_o = start_q;
   assign dma_burst_len_o   = len_q;
   assign burst_count_o     = burst_cnt;
   assign error_o           = error_q;

   dma_skid_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (SKID_DEPTH)
   ) u_skid (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .push_i     (skid_push),
      .push_dat_i (fifo_rd_dat_i),
      .pop_i      (xfer),
      .head_dat_o (skid_head),
      .occ_o      (skid_occ),
      .empty_o    (skid_empty),
      .full_o     (skid_full)
   );

   // Burst FSM with read/output counters and completed-burst count.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state     <= IDLE;
         len_q     <= '0;
         rd_left   <= '0;
         out_idx   <= '0;
         start_q   <= 1'b0;
         burst_cnt <= '0;
      end else begin
         start_q <= 1'b0;
         if (xfer)      out_idx <= out_idx + 16'd1;
         if (fifo_rd_o) rd_left <= rd_left - 16'd1;
         case (state)
            IDLE: begin
               if (arm) begin
                  state   <= READ;
                  len_q   <= arm_len;
                  rd_left <= arm_len;
                  out_idx <= '0;
                  start_q <= 1'b1;
               end
            end
            READ: begin
               if (rd_left == 16'd0) state <= DRAIN;
            end
            DRAIN: begin
               if (xfer && last_word) begin
                  state     <= IDLE;
                  burst_cnt <= burst_cnt + 32'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Idle timeout as a down-counter; reaching 0 means TIMEOUT non-empty idle cycles.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
         timer <= TIMEOUT_C;
      else if ((state != IDLE) || fifo_empty_i || arm)
         timer <= TIMEOUT_C;
      else if (timer != 16'd0)
         timer <= timer - 16'd1;
   end

   // Outstanding read tracking and sticky protocol error.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         inflight <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         inflight <= fifo_rd_o || (inflight && !fifo_rd_dat_valid_i);
         if (fifo_rd_dat_valid_i && (!inflight || skid_full))
            error_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dma_burst_reader.sv
// Directed bench for dma_burst_reader with a behavioural merge FIFO in front.
module tb_dma_burst_reader;

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic        enable_i;
   logic        flush_i;
   logic        fifo_rd_o;
   logic [31:0] fifo_rd_dat_i;
   logic        fifo_rd_dat_valid_i;
   logic        fifo_empty_i;
   logic [27:0] fifo_rd_data_count_i;
   logic [31:0] dma_dat_o;
   logic        dma_valid_o;
   logic        dma_ready_i;
   logic        dma_last_o;
   logic        dma_burst_start_o;
   logic [15:0] dma_burst_len_o;
   logic        busy_o;
   logic [31:0] burst_count_o;
   logic        error_o;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_bursts = 0;

   dma_burst_reader dut (
      .clk_i                (clk_i),
      .reset_n_i            (reset_n_i),
      .enable_i             (enable_i),
      .flush_i              (flush_i),
      .fifo_rd_o            (fifo_rd_o),
      .fifo_rd_dat_i        (fifo_rd_dat_i),
      .fifo_rd_dat_valid_i  (fifo_rd_dat_valid_i),
      .fifo_empty_i         (fifo_empty_i),
      .fifo_rd_data_count_i (fifo_rd_data_count_i),
      .dma_dat_o            (dma_dat_o),
      .dma_valid_o          (dma_valid_o),
      .dma_ready_i          (dma_ready_i),
      .dma_last_o           (dma_last_o),
      .dma_burst_start_o    (dma_burst_start_o),
      .dma_burst_len_o      (dma_burst_len_o),
      .busy_o               (busy_o),
      .burst_count_o        (burst_count_o),
      .error_o              (error_o)
   );

   always #5 clk_i = ~clk_i;

   // Merge FIFO model: words written by the tasks, read with 1-cycle latency.
   logic [31:0] src [0:511];
   int          wr_idx = 0;
   int          rd_idx = 0;
   logic        force_empty = 1'b0;
   logic        drop_req = 1'b0;
   logic        spur_valid = 1'b0;
   logic        model_valid = 1'b0;
   logic [31:0] model_dat = '0;
   int          rd_empty_err = 0;

   assign fifo_empty_i         = (wr_idx == rd_idx) || force_empty;
   assign fifo_rd_data_count_i = 28'(wr_idx - rd_idx);
   assign fifo_rd_dat_valid_i  = model_valid || spur_valid;
   assign fifo_rd_dat_i        = model_dat;

   always @(posedge clk_i) begin
      if (drop_req)       rd_idx <= wr_idx;
      else if (fifo_rd_o) rd_idx <= rd_idx + 1;
      model_valid <= fifo_rd_o && !drop_req;
      model_dat   <= src[rd_idx];
      if (fifo_rd_o && fifo_empty_i) rd_empty_err <= rd_empty_err + 1;
   end

   // Stream monitor.
   logic [31:0] rxq [$];
   logic        rxl [$];
   int          n_start = 0;
   int          n_rd = 0;

   always @(posedge clk_i) begin
      if (dma_valid_o && dma_ready_i) begin
         rxq.push_back(dma_dat_o);
         rxl.push_back(dma_last_o);
      end
      if (dma_burst_start_o) n_start <= n_start + 1;
      if (fifo_rd_o)         n_rd <= n_rd + 1;
   end

   task automatic push_words(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         src[wr_idx] = base + 32'(i);
         wr_idx = wr_idx + 1;
      end
   endtask

   task automatic wait_bursts(input int target, input int budget, output bit ok);
      int i = 0;
      ok = 0;
      while (!ok && i < budget) begin
         @(negedge clk_i);
         ok = (burst_count_o == 32'(target));
         i++;
      end
   endtask

   // Counts words of a received range that differ from base+k or carry a wrong last flag.
   task automatic count_bad(input int rx0, input int n, input logic [31:0] base,
                            input int blen, output int bad);
      bad = 0;
      for (int i = 0; i < n; i++) begin
         if (rx0 + i >= rxq.size()) bad++;
         else if (rxq[rx0+i] !== base + 32'(i) || rxl[rx0+i] !== ((i % blen) == blen - 1))
            bad++;
      end
   endtask

   task automatic test_reset();
      reset_n_i = 1'b0; enable_i = 1'b0; flush_i = 1'b0; dma_ready_i = 1'b0;
      repeat (3) @(negedge clk_i);
      n_cmp++;
      if ({busy_o, dma_valid_o, dma_last_o, dma_burst_start_o, fifo_rd_o, error_o} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_flags: got %b required 000000",
                  {busy_o, dma_valid_o, dma_last_o, dma_burst_start_o, fifo_rd_o, error_o});
      end
      n_cmp++;
      if ({dma_burst_len_o, burst_count_o, dma_dat_o} !== 80'd0) begin
         n_bad++;
         $display("FAIL reset_values: len %0d count %0d dat %h required 0",
                  dma_burst_len_o, burst_count_o, dma_dat_o);
      end
      reset_n_i = 1'b1;
      repeat (2) @(negedge clk_i);
      n_cmp++;
      if (busy_o !== 1'b0 || fifo_rd_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release_idle: busy %b rd %b required 0 0", busy_o, fifo_rd_o);
      end
   endtask

   task automatic test_full_burst();
      int rd0, st0, rx0, bad;
      bit ok;
      rd0 = n_rd; st0 = n_start; rx0 = rxq.size();
      dma_ready_i = 1'b1; enable_i = 1'b1;
      push_words(64, 32'h1000_0000);
      @(negedge clk_i);
      n_cmp++;
      if (dma_burst_start_o !== 1'b1 || dma_burst_len_o !== 16'd64 || busy_o !== 1'b1) begin
         n_bad++;
         $display("FAIL t1_arm: start %b len %0d busy %b required 1 64 1",
                  dma_burst_start_o, dma_burst_len_o, busy_o);
      end
      exp_bursts++;
      wait_bursts(exp_bursts, 400, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL t1_done: burst_count %0d required %0d", burst_count_o, exp_bursts);
      end
      n_cmp++;
      if (n_rd - rd0 != 64 || n_start - st0 != 1 || rxq.size() - rx0 != 64) begin
         n_bad++;
         $display("FAIL t1_counts: reads %0d starts %0d words %0d required 64 1 64",
                  n_rd - rd0, n_start - st0, rxq.size() - rx0);
      end
      count_bad(rx0, 64, 32'h1000_0000, 64, bad);
      n_cmp++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL t1_stream: %0d bad words required 0", bad);
      end
   endtask

   task automatic test_random_ready();
      int rd0, st0, rx0, bad, i;
      bit ok;
      rd0 = n_rd; st0 = n_start; rx0 = rxq.size();
      push_words(200, 32'h2000_0000);
      exp_bursts += 3;
      ok = 0; i = 0;
      while (!ok && i < 3000) begin
         @(negedge clk_i);
         ok = (burst_count_o == 32'(exp_bursts));
         dma_ready_i = ok ? 1'b1 : 1'($urandom_range(0, 1));
         i++;
      end
      enable_i = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL t2_done: burst_count %0d required %0d", burst_count_o, exp_bursts);
      end
      n_cmp++;
      if (n_rd - rd0 != 192 || n_start - st0 != 3 || rxq.size() - rx0 != 192) begin
         n_bad++;
         $display("FAIL t2_counts: reads %0d starts %0d words %0d required 192 3 192",
                  n_rd - rd0, n_start - st0, rxq.size() - rx0);
      end
      count_bad(rx0, 192, 32'h2000_0000, 64, bad);
      n_cmp++;
      if (bad != 0 || error_o !== 1'b0) begin
         n_bad++;
         $display("FAIL t2_stream: %0d bad words error %b required 0 0", bad, error_o);
      end
      repeat (3) @(negedge clk_i);
      n_cmp++;
      if (wr_idx - rd_idx != 8 || busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL t2_left: remaining %0d busy %b required 8 0", wr_idx - rd_idx, busy_o);
      end
      rx0 = rxq.size();
      enable_i = 1'b1; flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      n_cmp++;
      if (dma_burst_start_o !== 1'b1 || dma_burst_len_o !== 16'd8) begin
         n_bad++;
         $display("FAIL t2_tail_arm: start %b len %0d required 1 8", dma_burst_start_o, dma_burst_len_o);
      end
      exp_bursts++;
      wait_bursts(exp_bursts, 100, ok);
      count_bad(rx0, 8, 32'h2000_00C0, 8, bad);
      n_cmp++;
      if (!ok || bad != 0 || rxq.size() - rx0 != 8) begin
         n_bad++;
         $display("FAIL t2_tail: done %0d bad %0d words %0d required 1 0 8", ok, bad, rxq.size() - rx0);
      end
   endtask

   task automatic test_timeout();
      int st0, rx0, bad;
      bit ok;
      repeat (2) @(negedge clk_i);
      st0 = n_start; rx0 = rxq.size();
      push_words(5, 32'h3000_0000);
      repeat (1024) @(negedge clk_i);
      n_cmp++;
      if (busy_o !== 1'b0 || n_start != st0) begin
         n_bad++;
         $display("FAIL t3_early: busy %b starts %0d required 0 0", busy_o, n_start - st0);
      end
      @(negedge clk_i);
      n_cmp++;
      if (dma_burst_start_o !== 1'b1 || dma_burst_len_o !== 16'd5) begin
         n_bad++;
         $display("FAIL t3_arm: start %b len %0d required 1 5", dma_burst_start_o, dma_burst_len_o);
      end
      exp_bursts++;
      wait_bursts(exp_bursts, 100, ok);
      count_bad(rx0, 5, 32'h3000_0000, 5, bad);
      n_cmp++;
      if (!ok || bad != 0 || rxq.size() - rx0 != 5) begin
         n_bad++;
         $display("FAIL t3_stream: done %0d bad %0d words %0d required 1 0 5", ok, bad, rxq.size() - rx0);
      end
   endtask

   task automatic test_flush();
      int st0, rx0, bad;
      bit ok;
      repeat (2) @(negedge clk_i);
      st0 = n_start; rx0 = rxq.size();
      push_words(3, 32'h4000_0000);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      n_cmp++;
      if (dma_burst_start_o !== 1'b1 || dma_burst_len_o !== 16'd3) begin
         n_bad++;
         $display("FAIL t4_arm: start %b len %0d required 1 3", dma_burst_start_o, dma_burst_len_o);
      end
      push_words(2, 32'h4000_0003);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      exp_bursts++;
      wait_bursts(exp_bursts, 100, ok);
      n_cmp++;
      if (!ok || n_start - st0 != 1 || rxq.size() - rx0 != 3 || dma_burst_len_o !== 16'd3) begin
         n_bad++;
         $display("FAIL t4_ignore: done %0d starts %0d words %0d len %0d required 1 1 3 3",
                  ok, n_start - st0, rxq.size() - rx0, dma_burst_len_o);
      end
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      n_cmp++;
      if (dma_burst_start_o !== 1'b1 || dma_burst_len_o !== 16'd2) begin
         n_bad++;
         $display("FAIL t4_rest_arm: start %b len %0d required 1 2", dma_burst_start_o, dma_burst_len_o);
      end
      exp_bursts++;
      wait_bursts(exp_bursts, 100, ok);
      count_bad(rx0, 3, 32'h4000_0000, 3, bad);
      n_cmp++;
      if (!ok || bad != 0 || rxq.size() - rx0 != 5 || rxq[rx0+3] !== 32'h4000_0003
          || rxq[rx0+4] !== 32'h4000_0004 || rxl[rx0+3] !== 1'b0 || rxl[rx0+4] !== 1'b1) begin
         n_bad++;
         $display("FAIL t4_stream: done %0d bad %0d words %0d required 1 0 5", ok, bad, rxq.size() - rx0);
      end
   endtask

   task automatic test_empty_pause();
      int rd0, rx0, bad, i, rd_hits, idle_hits;
      bit ok;
      repeat (2) @(negedge clk_i);
      rd0 = n_rd; rx0 = rxq.size();
      push_words(64, 32'h5000_0000);
      i = 0;
      while (n_rd - rd0 != 10 && i < 100) begin
         @(negedge clk_i);
         i++;
      end
      force_empty = 1'b1;
      n_cmp++;
      if (n_rd - rd0 != 10) begin
         n_bad++;
         $display("FAIL t5_reach10: reads %0d required 10", n_rd - rd0);
      end
      rd_hits = 0; idle_hits = 0;
      for (int k = 0; k < 50; k++) begin
         #1;
         if (fifo_rd_o !== 1'b0) rd_hits++;
         if (busy_o !== 1'b1) idle_hits++;
         @(negedge clk_i);
      end
      n_cmp++;
      if (rd_hits != 0 || idle_hits != 0 || n_rd - rd0 != 10) begin
         n_bad++;
         $display("FAIL t5_pause: rd cycles %0d idle cycles %0d reads %0d required 0 0 10",
                  rd_hits, idle_hits, n_rd - rd0);
      end
      force_empty = 1'b0;
      exp_bursts++;
      wait_bursts(exp_bursts, 400, ok);
      count_bad(rx0, 64, 32'h5000_0000, 64, bad);
      n_cmp++;
      if (!ok || bad != 0 || n_rd - rd0 != 64 || rxq.size() - rx0 != 64) begin
         n_bad++;
         $display("FAIL t5_stream: done %0d bad %0d reads %0d words %0d required 1 0 64 64",
                  ok, bad, n_rd - rd0, rxq.size() - rx0);
      end
      n_cmp++;
      if (rd_empty_err != 0) begin
         n_bad++;
         $display("FAIL read_while_empty: %0d reads required 0", rd_empty_err);
      end
   endtask

   task automatic test_reset_midburst();
      int rx0, i;
      repeat (2) @(negedge clk_i);
      rx0 = rxq.size();
      push_words(64, 32'h6000_0000);
      i = 0;
      while (rxq.size() - rx0 < 20 && i < 200) begin
         @(negedge clk_i);
         i++;
      end
      n_cmp++;
      if (rxq.size() - rx0 != 20 || busy_o !== 1'b1) begin
         n_bad++;
         $display("FAIL t6_reach20: words %0d busy %b required 20 1", rxq.size() - rx0, busy_o);
      end
      reset_n_i = 1'b0;
      #1;
      n_cmp++;
      if ({busy_o, dma_valid_o, dma_last_o, dma_burst_start_o, fifo_rd_o, error_o} !== 6'b0
          || dma_burst_len_o !== 16'd0 || burst_count_o !== 32'd0) begin
         n_bad++;
         $display("FAIL t6_reset: flags %b len %0d count %0d required 000000 0 0",
                  {busy_o, dma_valid_o, dma_last_o, dma_burst_start_o, fifo_rd_o, error_o},
                  dma_burst_len_o, burst_count_o);
      end
      drop_req = 1'b1;
      repeat (3) @(negedge clk_i);
      drop_req = 1'b0;
      reset_n_i = 1'b1;
      repeat (2) @(negedge clk_i);
      n_cmp++;
      if (busy_o !== 1'b0 || error_o !== 1'b0 || dma_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL t6_after: busy %b error %b valid %b required 0 0 0", busy_o, error_o, dma_valid_o);
      end
      spur_valid = 1'b1;
      @(negedge clk_i);
      spur_valid = 1'b0;
      n_cmp++;
      if (error_o !== 1'b1) begin
         n_bad++;
         $display("FAIL t6_error_set: error %b required 1", error_o);
      end
      repeat (5) @(negedge clk_i);
      n_cmp++;
      if (error_o !== 1'b1 || busy_o !== 1'b0) begin
         n_bad++;
         $display("FAIL t6_error_sticky: error %b busy %b required 1 0", error_o, busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_full_burst();
      test_random_ready();
      test_timeout();
      test_flush();
      test_empty_pause();
      test_reset_midburst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
